// File: rtl/mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_controller
// Purpose  : Multicycle main controller for the tinymips core. Sequences the
//            shared unified memory, ALU, register file and PC through
//            fetch / decode / execute / writeback. A mem_ready handshake lets
//            a slow memory stall FETCH, MEMRD and MEMWR.
// Ports    : CLK, RST_N        - clock (rising edge), async active-low reset
//            opcode, funct     - instruction fields from the IR
//            zero              - ALU zero flag (branch decision)
//            mem_ready         - memory access completes this cycle
//            iord, irwrite, pcen, regdst, mem2reg, alusrca, alusrcb,
//            pcsrc, alu_control, regwrite, memwrite - datapath controls
//            illegal           - sticky unsupported-instruction flag
//            instret           - retired-instruction counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic             regdst,
  output logic             mem2reg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alu_control,
  output logic             regwrite,
  output logic             memwrite,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  // Opcodes
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  // R-type functs
  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic             retire_d;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;
  logic             funct_ok;

  // Only these five R-type functions are implemented; anything else traps.
  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      C_FN_ADD, C_FN_SUB, C_FN_AND, C_FN_OR, C_FN_SLT: funct_ok = 1'b1;
      default:                                         funct_ok = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state and retire decision
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          C_OP_LW, C_OP_SW: state_d = S_MEMADR;
          C_OP_RTYPE:       state_d = funct_ok ? S_EXECUTE : S_TRAP;
          C_OP_BEQ:         state_d = S_BRANCH;
          C_OP_ADDI:        state_d = S_ADDIEX;
          C_OP_J:           state_d = S_JUMP;
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == C_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_BRANCH: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_JUMP: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, sticky illegal flag and retired-instruction counter
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      // Raised on entry so the flag is already high in the first TRAP cycle.
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
      if (retire_d) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Decoded straight from state_q so that an asynchronous
  // reset (state_q -> IDLE) drops every enable immediately, without waiting
  // for a clock edge. mem_ready and zero enter only the Mealy terms.
  // --------------------------------------------------------------------------
  always_comb begin
    iord        = 1'b0;
    irwrite     = 1'b0;
    pcen        = 1'b0;
    regdst      = 1'b0;
    mem2reg     = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    alu_control = 3'b000;
    regwrite    = 1'b0;
    memwrite    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 computed and latched in the same cycle the IR loads.
        alusrcb     = 2'b01;
        alu_control = C_ALU_ADD;
        irwrite     = mem_ready;
        pcen        = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target (PC + imm<<2) into ALUOut.
        alusrcb     = 2'b11;
        alu_control = C_ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        alu_control = C_ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem2reg  = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          C_FN_SUB: alu_control = C_ALU_SUB;
          C_FN_AND: alu_control = C_ALU_AND;
          C_FN_OR:  alu_control = C_ALU_OR;
          C_FN_SLT: alu_control = C_ALU_SLT;
          default:  alu_control = C_ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        alu_control = C_ALU_SUB;
        pcsrc       = 2'b01;
        pcen        = zero;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_controller
// Purpose  : Directed self-checking bench for mips_mc_controller. Control
//            outputs are packed into one vector and compared per cycle
//            against hand-written per-state expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_controller;

  logic        CLK;
  logic        RST_N;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        iord, irwrite, pcen, regdst, mem2reg, alusrca;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alu_control;
  logic        regwrite, memwrite, illegal;
  logic [31:0] instret;

  int n_checks = 0;
  int n_fail   = 0;
  int mw_cnt;

  mips_mc_controller #(.CNT_W(32)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .iord        (iord),
    .irwrite     (irwrite),
    .pcen        (pcen),
    .regdst      (regdst),
    .mem2reg     (mem2reg),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .pcsrc       (pcsrc),
    .alu_control (alu_control),
    .regwrite    (regwrite),
    .memwrite    (memwrite),
    .illegal     (illegal),
    .instret     (instret)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {iord, irwrite, pcen, regdst, mem2reg, alusrca, alusrcb, pcsrc, alu, rw, mw}
  logic [14:0] ctrl;
  assign ctrl = {iord, irwrite, pcen, regdst, mem2reg, alusrca, alusrcb,
                 pcsrc, alu_control, regwrite, memwrite};

  function automatic logic [14:0] cv(input logic io, input logic irw,
      input logic pe, input logic rd, input logic m2r, input logic asa,
      input logic [1:0] asb, input logic [1:0] pcs, input logic [2:0] alu,
      input logic rw, input logic mw);
    return {io, irw, pe, rd, m2r, asa, asb, pcs, alu, rw, mw};
  endfunction

  // Hand-derived expected control vectors per state
  logic [14:0] E_IDLE, E_FETCH, E_FETCH_W, E_DECODE, E_MEMADR, E_MEMRD,
               E_MEMWB, E_MEMWR, E_SUB, E_SLT, E_ALUWB, E_BEQ_T, E_BEQ_N,
               E_ADDIEX, E_ADDIWB, E_JUMP;
  initial begin
    E_IDLE    = '0;
    E_FETCH   = cv(0,1,1,0,0,0,2'b01,2'b00,3'b010,0,0);
    E_FETCH_W = cv(0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    E_DECODE  = cv(0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0);
    E_MEMADR  = cv(0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
    E_MEMRD   = cv(1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    E_MEMWB   = cv(0,0,0,0,1,0,2'b00,2'b00,3'b000,1,0);
    E_MEMWR   = cv(1,0,0,0,0,0,2'b00,2'b00,3'b000,0,1);
    E_SUB     = cv(0,0,0,0,0,1,2'b00,2'b00,3'b110,0,0);
    E_SLT     = cv(0,0,0,0,0,1,2'b00,2'b00,3'b111,0,0);
    E_ALUWB   = cv(0,0,0,1,0,0,2'b00,2'b00,3'b000,1,0);
    E_BEQ_T   = cv(0,0,1,0,0,1,2'b00,2'b01,3'b110,0,0);
    E_BEQ_N   = cv(0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0);
    E_ADDIEX  = cv(0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
    E_ADDIWB  = cv(0,0,0,0,0,0,2'b00,2'b00,3'b000,1,0);
    E_JUMP    = cv(0,0,1,0,0,0,2'b00,2'b10,3'b000,0,0);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: settle, compare the current state's outputs, advance.
  task automatic cyc(input string tag, input logic [14:0] exp);
    #1;
    check(tag, {17'd0, ctrl}, {17'd0, exp});
    if (memwrite === 1'b1) mw_cnt++;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    check("rst_ctrl",    {17'd0, ctrl}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_instret", instret, 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    mw_cnt = 0;
    @(posedge CLK);
    #1;
    do_reset();

    // lw, memory always ready: 5 cycles after IDLE
    opcode = 6'b100011;
    cyc("lw_idle",   E_IDLE);
    cyc("lw_fetch",  E_FETCH);
    cyc("lw_decode", E_DECODE);
    cyc("lw_memadr", E_MEMADR);
    cyc("lw_memrd",  E_MEMRD);
    cyc("lw_memwb",  E_MEMWB);
    check("lw_instret", instret, 32'd1);

    // sw with three stall cycles in MEMWR
    opcode = 6'b101011; mw_cnt = 0;
    cyc("sw_fetch",  E_FETCH);
    cyc("sw_decode", E_DECODE);
    cyc("sw_memadr", E_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", E_MEMWR);
    mem_ready = 1'b1;
    cyc("sw_memwr_done", E_MEMWR);
    check("sw_memwrite_cycles", mw_cnt, 32'd4);
    check("sw_instret", instret, 32'd2);

    // R-type sub then slt
    opcode = 6'b000000; funct = 6'b100010;
    cyc("sub_fetch",  E_FETCH);
    cyc("sub_decode", E_DECODE);
    cyc("sub_exec",   E_SUB);
    cyc("sub_aluwb",  E_ALUWB);
    check("sub_instret", instret, 32'd3);
    funct = 6'b101010;
    cyc("slt_fetch",  E_FETCH);
    cyc("slt_decode", E_DECODE);
    cyc("slt_exec",   E_SLT);
    cyc("slt_aluwb",  E_ALUWB);
    check("slt_instret", instret, 32'd4);

    // beq taken, then not taken; both retire
    opcode = 6'b000100; zero = 1'b1;
    cyc("beqt_fetch",  E_FETCH);
    cyc("beqt_decode", E_DECODE);
    cyc("beqt_branch", E_BEQ_T);
    zero = 1'b0;
    cyc("beqn_fetch",  E_FETCH);
    cyc("beqn_decode", E_DECODE);
    cyc("beqn_branch", E_BEQ_N);
    check("beq_instret", instret, 32'd6);

    // addi with a two-cycle fetch stall
    opcode = 6'b001000; mem_ready = 1'b0;
    cyc("addi_fetch_wait", E_FETCH_W);
    cyc("addi_fetch_wait", E_FETCH_W);
    mem_ready = 1'b1;
    cyc("addi_fetch",  E_FETCH);
    cyc("addi_decode", E_DECODE);
    cyc("addi_ex",     E_ADDIEX);
    cyc("addi_wb",     E_ADDIWB);
    check("addi_instret", instret, 32'd7);

    // j
    opcode = 6'b000010;
    cyc("j_fetch",  E_FETCH);
    cyc("j_decode", E_DECODE);
    cyc("j_jump",   E_JUMP);
    check("j_instret", instret, 32'd8);

    // Unsupported opcode traps and stays trapped
    opcode = 6'b111111;
    cyc("trap_fetch",  E_FETCH);
    cyc("trap_decode", E_DECODE);
    for (int i = 0; i < 10; i++) begin
      check("trap_illegal", {31'd0, illegal}, 32'd1);
      check("trap_instret", instret, 32'd8);
      cyc("trap_ctrl", E_IDLE);
    end
    do_reset();

    // R-type with unsupported funct also traps
    opcode = 6'b000000; funct = 6'b000000;
    cyc("badfn_idle",   E_IDLE);
    cyc("badfn_fetch",  E_FETCH);
    cyc("badfn_decode", E_DECODE);
    check("badfn_illegal", {31'd0, illegal}, 32'd1);
    cyc("badfn_trap", E_IDLE);
    do_reset();

    // Asynchronous reset in the middle of a store
    opcode = 6'b101011; mem_ready = 1'b1;
    cyc("asr_idle",   E_IDLE);
    cyc("asr_fetch",  E_FETCH);
    cyc("asr_decode", E_DECODE);
    mem_ready = 1'b0;
    cyc("asr_memadr", E_MEMADR);
    #1;
    check("asr_memwr", {31'd0, memwrite}, 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    check("asr_memwrite_drop", {31'd0, memwrite}, 32'd0);
    check("asr_ctrl_drop", {17'd0, ctrl}, 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1; mem_ready = 1'b1;
    cyc("asr_restart_idle",  E_IDLE);
    cyc("asr_restart_fetch", E_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multicycle main controller for the tinymips core: a Moore/Mealy FSM that sequences the shared memory, ALU, register file and PC through fetch/decode/execute.
- Replaces forced control in the single-cycle datapath; drives alu_control, regwrite, memwrite and mem2reg plus the multicycle mux selects.
- Sits beside the datapath; takes opcode/funct from the instruction register and zero from the ALU.
- A mem_ready handshake lets a slow unified memory stall the sequence.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
iord  out  1  memory address select: 0=PC, 1=ALUOut
irwrite  out  1  IR load enable
pcen  out  1  PC load enable
regdst  out  1  write register: 0=rt, 1=rd
mem2reg  out  1  writeback data: 0=ALUOut, 1=memory data
alusrca  out  1  ALU A: 0=PC, 1=reg A
alusrcb  out  2  ALU B: 00=reg B, 01=4, 10=sign-extended imm, 11=imm<<2
pcsrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
regwrite  out  1  register file write enable
memwrite  out  1  memory write enable
illegal  out  1  sticky unsupported-instruction flag
instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; instret=0; illegal=0. Every output is 0, including alu_control=000.
- Outputs are decoded from state. The Mealy terms (irwrite, pcen, memwrite gating) also use mem_ready and zero. Unlisted outputs are 0.
- IDLE: one cycle, then FETCH. A deassertion of RST_N takes effect at the next CLK edge.
- FETCH: iord=0, alusrca=0, alusrcb=01, alu_control=010, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Stay in FETCH while mem_ready=0. Go to DECODE on the edge with mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, alu_control=010 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode -> TRAP
  - R-type with funct outside {100000, 100010, 100100, 100101, 101010} -> TRAP
- MEMADR: alusrca=1, alusrcb=10, alu_control=010. Next MEMRD if opcode=100011, else MEMWR.
- MEMRD: iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: regdst=0, mem2reg=1, regwrite=1. Retire, then FETCH.
- MEMWR: iord=1, memwrite=1 held every cycle until mem_ready=1. Retire on that edge, then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alu_control from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - Next state ALUWB.
- ALUWB: regdst=1, mem2reg=0, regwrite=1. Retire, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, alu_control=110, pcsrc=01, pcen=zero. Retire, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alu_control=010. Next ADDIWB.
- ADDIWB: regdst=0, mem2reg=0, regwrite=1. Retire, then FETCH.
- JUMP: pcsrc=10, pcen=1. Retire, then FETCH.
- TRAP: all enables 0; illegal=1. Stays in TRAP until reset; instret frozen.
- Retire: instret increments by 1 on the leaving edge of MEMWB, MEMWR(ready), ALUWB, BRANCH, ADDIWB and JUMP.
  - instret wraps modulo 2^CNT_W.
- Latency with mem_ready tied high:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
- Each cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- At most one of regwrite/memwrite/irwrite is asserted in any cycle.

Test Plan:
- Reset then lw (opcode 100011), mem_ready=1 -> states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 with mem2reg=1 in cycle 6; instret=1.
- sw with mem_ready low for 3 MEMWR cycles -> memwrite=1 for exactly 4 cycles, iord=1, regwrite never 1; instret increments once.
- R-type funct 100010 then 101010 -> EXECUTE alu_control=110 then 111; ALUWB regdst=1, regwrite=1; 4 cycles each.
- beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH; repeat with zero=0 -> pcen=0; both retire (instret +2).
- opcode 111111 -> TRAP after DECODE; illegal=1, all enables 0 for 10 cycles. RST_N pulse -> illegal=0, instret=0.
- RST_N asserted mid-MEMWR with memwrite=1 -> memwrite drops to 0 immediately (asynchronously), without a clock edge. Restart begins at IDLE.
